// File: rtl/rot_coord_gen.sv
// Rotated-coordinate generator: raster-scans a 2^DIM_W square patch and streams each
// sample's position with its rotated, half-up rounded and saturated (u, v) coordinates.
module rot_coord_gen #(
  parameter int DIM_W  = 4,
  parameter int N_DIR  = 24,
  parameter int DIR_W  = 5,
  parameter int COEF_W = 10,
  parameter int FRAC   = 8,
  parameter int OUT_W  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_we,
  input  logic [DIR_W-1:0]  cfg_addr,
  input  logic [COEF_W-1:0] cfg_cos,
  input  logic [COEF_W-1:0] cfg_sin,
  input  logic              start,
  input  logic [DIR_W-1:0]  dir,
  output logic              busy,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DIM_W-1:0]  out_row,
  output logic [DIM_W-1:0]  out_col,
  output logic [OUT_W-1:0]  out_u,
  output logic [OUT_W-1:0]  out_v,
  output logic              out_last
);

  localparam int SIDE = 2 ** DIM_W;
  localparam int CW   = 2 * DIM_W;
  localparam int XW   = DIM_W + 2;
  localparam int PW   = DIM_W + COEF_W + 3;
  localparam logic signed [XW-1:0] CENTER  = XW'(SIDE - 1);
  localparam logic signed [PW-1:0] HALF    = PW'(2 ** FRAC);
  localparam logic signed [PW-1:0] SAT_MAX = PW'(2 ** (OUT_W - 1) - 1);
  localparam logic signed [PW-1:0] SAT_MIN = PW'(-(2 ** (OUT_W - 1)));

  logic signed [COEF_W-1:0] tab_cos [N_DIR];
  logic signed [COEF_W-1:0] tab_sin [N_DIR];
  logic signed [COEF_W-1:0] w_cos, w_sin;

  logic          gen_active;
  logic [CW-1:0] cnt;

  logic                 s0_valid, s0_last;
  logic [DIM_W-1:0]     s0_row, s0_col;
  logic signed [XW-1:0] s0_x2, s0_y2;

  logic                 s1_valid, s1_last;
  logic [DIM_W-1:0]     s1_row, s1_col;
  logic signed [PW-1:0] s1_xc, s1_ys, s1_yc, s1_xs;

  logic en, accept, dir_ok, addr_ok;
  logic signed [XW-1:0] x2_n, y2_n;
  logic signed [PW-1:0] xw, yw, cw, sw;
  logic signed [PW-1:0] su, sv, ru, rv;

  // The whole pipeline advances together; only a stalled output beat freezes it.
  assign en      = !out_valid || out_ready;
  assign dir_ok  = {1'b0, dir} < (DIR_W + 1)'(N_DIR);
  assign addr_ok = {1'b0, cfg_addr} < (DIR_W + 1)'(N_DIR);
  assign accept  = start && !busy && dir_ok;

  assign x2_n = $signed({1'b0, cnt[DIM_W-1:0], 1'b0}) - CENTER;
  assign y2_n = $signed({1'b0, cnt[CW-1:DIM_W], 1'b0}) - CENTER;

  assign xw = {{(PW - XW){s0_x2[XW-1]}}, s0_x2};
  assign yw = {{(PW - XW){s0_y2[XW-1]}}, s0_y2};
  assign cw = {{(PW - COEF_W){w_cos[COEF_W-1]}}, w_cos};
  assign sw = {{(PW - COEF_W){w_sin[COEF_W-1]}}, w_sin};

  assign su = s1_xc + s1_ys;
  assign sv = s1_yc - s1_xs;
  assign ru = (su + HALF) >>> (FRAC + 1);
  assign rv = (sv + HALF) >>> (FRAC + 1);

  function automatic logic [OUT_W-1:0] sat(input logic signed [PW-1:0] x);
    logic signed [PW-1:0] y;
    y = x;
    if (x > SAT_MAX) y = SAT_MAX;
    if (x < SAT_MIN) y = SAT_MIN;
    return y[OUT_W-1:0];
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_DIR; i++) begin
        tab_cos[i] <= '0;
        tab_sin[i] <= '0;
      end
      w_cos      <= '0;
      w_sin      <= '0;
      busy       <= 1'b0;
      gen_active <= 1'b0;
      cnt        <= '0;
      s0_valid   <= 1'b0;
      s0_last    <= 1'b0;
      s0_row     <= '0;
      s0_col     <= '0;
      s0_x2      <= '0;
      s0_y2      <= '0;
      s1_valid   <= 1'b0;
      s1_last    <= 1'b0;
      s1_row     <= '0;
      s1_col     <= '0;
      s1_xc      <= '0;
      s1_ys      <= '0;
      s1_yc      <= '0;
      s1_xs      <= '0;
      out_valid  <= 1'b0;
      out_last   <= 1'b0;
      out_row    <= '0;
      out_col    <= '0;
      out_u      <= '0;
      out_v      <= '0;
    end else begin
      if (cfg_we && addr_ok) begin
        tab_cos[cfg_addr] <= cfg_cos;
        tab_sin[cfg_addr] <= cfg_sin;
      end

      if (out_valid && out_ready && out_last) busy <= 1'b0;

      if (en) begin
        s0_valid <= gen_active;
        if (gen_active) begin
          s0_row  <= cnt[CW-1:DIM_W];
          s0_col  <= cnt[DIM_W-1:0];
          s0_x2   <= x2_n;
          s0_y2   <= y2_n;
          s0_last <= &cnt;
          cnt     <= cnt + 1'b1;
          if (&cnt) gen_active <= 1'b0;
        end

        s1_valid <= s0_valid;
        s1_last  <= s0_last;
        s1_row   <= s0_row;
        s1_col   <= s0_col;
        s1_xc    <= xw * cw;
        s1_ys    <= yw * sw;
        s1_yc    <= yw * cw;
        s1_xs    <= xw * sw;

        out_valid <= s1_valid;
        out_last  <= s1_valid && s1_last;
        out_row   <= s1_row;
        out_col   <= s1_col;
        out_u     <= sat(ru);
        out_v     <= sat(rv);
      end

      // Coefficients are latched here so later table writes cannot reach a running scan.
      if (accept) begin
        busy       <= 1'b1;
        gen_active <= 1'b1;
        cnt        <= '0;
        w_cos      <= tab_cos[dir];
        w_sin      <= tab_sin[dir];
      end
    end
  end

endmodule

// File: tb/tb_rot_coord_gen.sv
// Bench for rot_coord_gen: random coefficients and backpressure checked against an
// arithmetic model of the rotated-coordinate rules through an expected-beat queue.
module tb_rot_coord_gen;

  localparam int DIM_W = 4;
  localparam int N_DIR = 24;
  localparam int DIR_W = 5;
  localparam int COEF_W = 10;
  localparam int OUT_W = 5;
  localparam int SIDE = 16;
  localparam int BW = 2 * DIM_W + 2 * OUT_W + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cfg_we = 1'b0;
  logic [DIR_W-1:0] cfg_addr = '0;
  logic [COEF_W-1:0] cfg_cos = '0, cfg_sin = '0;
  logic start = 1'b0;
  logic [DIR_W-1:0] dir = '0;
  logic busy, out_valid, out_last;
  logic out_ready = 1'b1;
  logic [DIM_W-1:0] out_row, out_col;
  logic [OUT_W-1:0] out_u, out_v;

  rot_coord_gen dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_cos(cfg_cos), .cfg_sin(cfg_sin), .start(start), .dir(dir),
    .busy(busy), .out_valid(out_valid), .out_ready(out_ready),
    .out_row(out_row), .out_col(out_col), .out_u(out_u), .out_v(out_v),
    .out_last(out_last)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  logic [BW-1:0] exp_q[$];
  int m_cos [N_DIR];
  int m_sin [N_DIR];
  int got_u [SIDE*SIDE];
  int got_v [SIDE*SIDE];
  int got_last [SIDE*SIDE];
  int beat_cnt = 0;
  bit ready_mode = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Half-up rounding of s / 2^(FRAC+1) done as floor division, then clamped.
  function automatic int rnd_sat(input int s);
    int t, q;
    t = s + 256;
    if (t >= 0) q = t / 512;
    else q = -((-t + 511) / 512);
    if (q > 15) q = 15;
    if (q < -16) q = -16;
    return q;
  endfunction

  function automatic logic [BW-1:0] model_beat(input int r, input int c, input int co, input int si);
    int x2, y2, u, v;
    logic [3:0] rr, cc;
    logic [4:0] uu, vv;
    x2 = 2 * c - (SIDE - 1);
    y2 = 2 * r - (SIDE - 1);
    u = rnd_sat(x2 * co + y2 * si);
    v = rnd_sat(y2 * co - x2 * si);
    rr = r[3:0];
    cc = c[3:0];
    uu = u[4:0];
    vv = v[4:0];
    return {rr, cc, uu, vv, (r == SIDE - 1 && c == SIDE - 1)};
  endfunction

  // Downstream ready, redrawn each cycle just after the clock edge.
  always @(posedge clk) begin
    #1;
    out_ready = ready_mode ? ($urandom_range(0, 3) != 0) : 1'b1;
  end

  // Monitor: pops the scoreboard on each transfer and checks stall stability.
  bit hold_prev = 0;
  logic [BW-1:0] held;
  always @(negedge clk) begin
    logic [BW-1:0] b;
    b = {out_row, out_col, out_u, out_v, out_last};
    if (rst) begin
      hold_prev = 0;
    end else begin
      if (hold_prev) begin
        if (out_valid) check("stall_hold", b, held);
        else check("valid_drop", 0, 1);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("spurious_beat", 1, 0);
        else check("beat", b, exp_q.pop_front());
        got_u[out_row * SIDE + out_col] = $signed(out_u);
        got_v[out_row * SIDE + out_col] = $signed(out_v);
        got_last[out_row * SIDE + out_col] = out_last;
        beat_cnt++;
      end
      hold_prev = out_valid && !out_ready;
      held = b;
    end
  end

  task automatic write_coef(input int a, input int co, input int si);
    @(posedge clk); #1;
    cfg_we = 1'b1;
    cfg_addr = DIR_W'(a);
    cfg_cos = COEF_W'(co);
    cfg_sin = COEF_W'(si);
    if (a < N_DIR) begin
      m_cos[a] = co;
      m_sin[a] = si;
    end
    @(posedge clk); #1;
    cfg_we = 1'b0;
  endtask

  task automatic begin_scan(input int d);
    @(posedge clk); #1;
    check("start_idle", busy, 0);
    for (int r = 0; r < SIDE; r++)
      for (int c = 0; c < SIDE; c++)
        exp_q.push_back(model_beat(r, c, m_cos[d], m_sin[d]));
    start = 1'b1;
    dir = DIR_W'(d);
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_rise", busy, 1);
    check("lat_t0", out_valid, 0);
    repeat (2) begin
      @(posedge clk); #1;
      check("lat_wait", out_valid, 0);
    end
    @(posedge clk); #1;
    check("lat_first", out_valid, 1);
  endtask

  task automatic wait_done(input string tag);
    bit ok;
    ok = 0;
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      if (!busy && exp_q.size() == 0) begin
        ok = 1;
        break;
      end
    end
    check(tag, ok, 1);
  endtask

  initial begin
    int base;
    for (int i = 0; i < N_DIR; i++) begin
      m_cos[i] = 0;
      m_sin[i] = 0;
    end
    repeat (3) @(posedge clk);
    #1;
    check("reset_out", {out_valid, busy, out_last, out_row, out_col, out_u, out_v}, 0);
    rst = 1'b0;

    // Identity rotation
    write_coef(0, 256, 0);
    base = beat_cnt;
    begin_scan(0);
    wait_done("id_done");
    check("id_beats", beat_cnt - base, 256);
    check("id_u00", got_u[0], -7);
    check("id_v00", got_v[0], -7);
    check("id_u0f", got_u[15], 8);
    check("id_v0f", got_v[15], -7);
    check("id_uff", got_u[255], 8);
    check("id_vff", got_v[255], 8);
    check("id_last", got_last[255], 1);
    check("id_notlast", got_last[254], 0);
    check("id_busy_low", busy, 0);

    // 90 degrees
    write_coef(6, 0, 256);
    begin_scan(6);
    wait_done("r90_done");
    check("r90_u00", got_u[0], -7);
    check("r90_v00", got_v[0], 8);
    check("r90_uf0", got_u[240], 8);
    check("r90_vf0", got_v[240], 8);

    // Saturation
    write_coef(23, 511, 511);
    begin_scan(23);
    wait_done("sat_done");
    check("sat_uff", got_u[255], 15);
    check("sat_vff", got_v[255], 0);
    check("sat_u00", got_u[0], -16);
    check("sat_v00", got_v[0], 0);

    // Random coefficients under random backpressure
    ready_mode = 1;
    for (int k = 0; k < 3; k++) begin
      int d;
      d = $urandom_range(0, N_DIR - 1);
      write_coef(d, int'($urandom_range(0, 1023)) - 512, int'($urandom_range(0, 1023)) - 512);
      write_coef(30, 100, 100);
      base = beat_cnt;
      begin_scan(d);
      wait_done("rnd_done");
      check("rnd_beats", beat_cnt - base, 256);
    end

    // Protocol: out-of-range dir, start while busy, mid-scan table write
    @(posedge clk); #1;
    start = 1'b1;
    dir = DIR_W'(24);
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      check("bad_dir_idle", {busy, out_valid}, 0);
    end
    write_coef(0, 181, -181);
    begin_scan(0);
    repeat (10) @(posedge clk);
    #1;
    start = 1'b1;
    dir = DIR_W'(6);
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_ign", busy, 1);
    write_coef(0, -256, 128);
    wait_done("mid_wr_done");
    begin_scan(0);
    wait_done("new_coef_done");

    // Reset in the middle of a scan
    ready_mode = 0;
    write_coef(0, 256, 0);
    begin_scan(0);
    base = beat_cnt - 1;
    for (int i = 0; i < 500; i++) begin
      @(posedge clk);
      if (beat_cnt - base >= 100) break;
    end
    check("rst_reach100", (beat_cnt - base >= 100), 1);
    #2;
    rst = 1'b1;
    exp_q.delete();
    for (int i = 0; i < N_DIR; i++) begin
      m_cos[i] = 0;
      m_sin[i] = 0;
    end
    #1;
    check("async_rst", {out_valid, busy, out_last, out_row, out_col, out_u, out_v}, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      check("post_rst_idle", {busy, out_valid}, 0);
    end
    begin_scan(0);
    wait_done("cleared_done");
    check("cleared_u", got_u[17], 0);
    check("cleared_v", got_v[17], 0);
    check("cleared_u00", got_u[0], 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
